// File: rtl/rgb_arbiter_if.sv
// Requester, result and colour-ROM signals of the RGB arbiter, grouped as one bus.
// The arbiter takes the slave side; the environment (requesters and ROM) takes the master side.
interface rgb_arbiter_if;
  logic        req0;
  logic        req1;
  logic [2:0]  colour0;
  logic [2:0]  colour1;
  logic        gnt0;
  logic        gnt1;
  logic        valid0;
  logic        valid1;
  logic [23:0] rgb_out;
  logic        busy;
  logic        rom_en;
  logic [2:0]  rom_addr;
  logic [23:0] rom_data;

  modport slave (
    input  req0, req1, colour0, colour1, rom_data,
    output gnt0, gnt1, valid0, valid1, rgb_out, busy, rom_en, rom_addr
  );

  modport master (
    output req0, req1, colour0, colour1, rom_data,
    input  gnt0, gnt1, valid0, valid1, rgb_out, busy, rom_en, rom_addr
  );
endinterface

// File: rtl/rgb_arbiter.sv
// Round-robin arbiter giving two requesters access to one colour ROM.
// Each transaction: grant + ROM read (ISSUE), wait READ_LATENCY cycles (WAIT), registered result.
module rgb_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  rgb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Latency is 1 or 2, so a single-bit counter covers the wait.
  localparam logic LAST = (READ_LATENCY == 2);

  state_t      state;
  state_t      state_next;
  logic        cnt;
  logic        prio;
  logic        owner;
  logic        pick0;
  logic        pick1;

  logic        gnt0_q;
  logic        gnt1_q;
  logic        valid0_q;
  logic        valid1_q;
  logic        busy_q;
  logic        rom_en_q;
  logic [2:0]  rom_addr_q;
  logic [23:0] rgb_q;

  // A lone request wins regardless of priority; prio=1 means requester 1 is favoured.
  always_comb begin
    pick0 = bus.req0 && (!bus.req1 || !prio);
    pick1 = bus.req1 && !pick0;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (bus.req0 || bus.req1) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      busy_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rgb_q      <= '0;
      cnt        <= 1'b0;
      prio       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      rom_en_q <= 1'b0;
      busy_q   <= (state_next != IDLE);
      case (state)
        IDLE: begin
          // rom_addr doubles as the latched colour index for the whole transaction.
          if (pick0) begin
            gnt0_q     <= 1'b1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= bus.colour0;
            owner      <= 1'b0;
            prio       <= 1'b1;
          end else if (pick1) begin
            gnt1_q     <= 1'b1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= bus.colour1;
            owner      <= 1'b1;
            prio       <= 1'b0;
          end
        end
        ISSUE: cnt <= 1'b0;
        WAIT: begin
          if (cnt == LAST) begin
            rgb_q    <= bus.rom_data;
            valid0_q <= !owner;
            valid1_q <= owner;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.valid0   = valid0_q;
  assign bus.valid1   = valid1_q;
  assign bus.busy     = busy_q;
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rgb_out  = rgb_q;

endmodule
